rf_cmd_ctrl: RTL

Command controller that sits directly upstream of the register file. It consumes parallel bytes from the UART receiver and decodes them as write or read frames. It drives the register file's Address/WrEn/RdEn/WrData bus and returns read data to the UART transmitter over a valid/ready handshake. An inter-byte timeout aborts incomplete frames.

---
 rtl/rf_cmd_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rf_cmd_ctrl.sv
// Byte-frame command controller in front of the register file: decodes
// write (op, addr, data) and read (op, addr) frames and returns read data to the UART TX.
module rf_cmd_ctrl #(
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] WR_CMD         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD         = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Ready,
  output logic                  Frame_Err,
  output logic                  Busy
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  // Read data may arrive in the first three RD_WAIT cycles; the error then
  // shows up on the fourth cycle after the RdEn pulse.
  localparam logic [1:0]      WAIT_LAST = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic             frame_err_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_run;
  logic [1:0]       wait_cnt;

  assign tmo_hit = (tmo_cnt == CNT_LIMIT);
  assign tmo_run = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);

  always_comb begin
    state_nxt     = state_q;
    frame_err_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_nxt = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_nxt = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          state_nxt = WR_DATA;
        end else if (tmo_hit) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          state_nxt = WR_EXEC;
        end else if (tmo_hit) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end
      end
      WR_EXEC: state_nxt = IDLE;
      RD_ADDR: begin
        if (RX_D_VLD) begin
          state_nxt = RD_EXEC;
        end else if (tmo_hit) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end
      end
      RD_EXEC: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (RdData_Valid) begin
          state_nxt = TX_SEND;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end
      end
      TX_SEND: begin
        if (TX_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are registered from the next state so strobes line up with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tmo_cnt   <= '0;
      wait_cnt  <= '0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if ((state_nxt != state_q) || RX_D_VLD) begin
        tmo_cnt <= '0;
      end else if (tmo_run) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (state_q == RD_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end else begin
        wait_cnt <= '0;
      end

      if (RX_D_VLD && ((state_q == WR_ADDR) || (state_q == RD_ADDR))) begin
        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
      end
      if (RX_D_VLD && (state_q == WR_DATA)) begin
        WrData <= RX_P_DATA;
      end
      if ((state_q == RD_WAIT) && RdData_Valid) begin
        TX_P_DATA <= RdData;
      end

      WrEn      <= (state_nxt == WR_EXEC);
      RdEn      <= (state_nxt == RD_EXEC);
      TX_D_VLD  <= (state_nxt == TX_SEND);
      Frame_Err <= frame_err_nxt;
      Busy      <= (state_nxt != IDLE);
    end
  end

endmodule
